// File: rtl/sseg_scanner_if.sv
// Bus between the display-value producer and the digit scanner.
interface sseg_scanner_if;
    logic [15:0] value;
    logic        load;
    logic        enable;
    logic [3:0]  digit;
    logic [1:0]  sel;
    logic        blank;
    logic        frame;

    modport master (output value, load, enable, input digit, sel, blank, frame);
    modport slave  (input value, load, enable, output digit, sel, blank, frame);
endinterface

// File: rtl/sseg_scanner.sv
// Four-digit seven-segment scanner: shadows a 16-bit value and multiplexes its
// nibbles onto digit/sel with a per-slot dead-time blank and a frame pulse.
module sseg_scanner #(
    parameter int unsigned PRESCALE = 50000,
    parameter int unsigned DEAD     = 16,
    parameter int unsigned CNT_W    = 16
) (
    input  logic          clk,
    input  logic          rst,
    sseg_scanner_if.slave bus
);
    localparam int unsigned VAL_W = 16;
    localparam int unsigned NIB_W = 4;
    localparam int unsigned SEL_W = 2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] CNT_DEAD = CNT_W'(DEAD);

    logic [VAL_W-1:0] shadow;
    logic [CNT_W-1:0] cnt;
    logic [SEL_W-1:0] sel_q;
    logic [NIB_W-1:0] digit_q;
    logic             blank_q;
    logic             frame_q;

    logic [VAL_W-1:0] shadow_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [SEL_W-1:0] sel_inc;
    logic [SEL_W-1:0] sel_pick;
    logic [NIB_W-1:0] nib_pick;
    logic             boundary;

    // Next-shadow lets a load on a boundary edge feed the entering position.
    always_comb begin
        shadow_nxt = bus.load ? bus.value : shadow;
        boundary   = bus.enable && (cnt == CNT_LAST);
        cnt_nxt    = (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
        sel_inc    = sel_q + SEL_W'(1);
        sel_pick   = boundary ? sel_inc : sel_q;
        nib_pick   = shadow_nxt[{sel_pick, 2'b00} +: NIB_W];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow  <= '0;
            cnt     <= '0;
            sel_q   <= '0;
            digit_q <= '0;
            blank_q <= 1'b1;
            frame_q <= 1'b0;
        end else begin
            shadow <= shadow_nxt;
            if (bus.enable) begin
                cnt     <= cnt_nxt;
                blank_q <= (cnt_nxt < CNT_DEAD);
                frame_q <= boundary && (sel_q == SEL_W'(3));
                if (boundary) begin
                    sel_q   <= sel_inc;
                    digit_q <= nib_pick;
                end
            end else begin
                // Frozen: keep position, blank, and track shadow so loads show.
                digit_q <= nib_pick;
                blank_q <= 1'b1;
                frame_q <= 1'b0;
            end
        end
    end

    assign bus.digit = digit_q;
    assign bus.sel   = sel_q;
    assign bus.blank = blank_q;
    assign bus.frame = frame_q;
endmodule

// File: tb/tb_sseg_scanner.sv
// Self-checking bench for sseg_scanner against a position-count reference model.
module tb_sseg_scanner;
    localparam int unsigned P = 8;
    localparam int unsigned D = 2;

    logic clk = 1'b0;
    logic rst;
    sseg_scanner_if bus ();

    sseg_scanner #(.PRESCALE(P), .DEAD(D), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference: m_pos counts enabled cycles within a frame (0 .. 4*P-1).
    int          m_pos;
    logic [15:0] m_shadow;
    logic [3:0]  m_digit;
    logic        m_blank;
    logic        m_frame;

    function automatic logic [3:0] nib(input logic [15:0] v, input int pos);
        return 4'((v >> (4 * pos)) & 16'hF);
    endfunction

    task automatic model_step();
        logic [15:0] nsh;
        if (rst) begin
            m_pos = 0; m_shadow = '0; m_digit = '0; m_blank = 1'b1; m_frame = 1'b0;
        end else begin
            nsh = bus.load ? bus.value : m_shadow;
            if (bus.enable) begin
                m_pos   = (m_pos + 1) % (4 * P);
                m_frame = (m_pos == 0);
                m_blank = (m_pos % P) < D;
                if (m_pos % P == 0) m_digit = nib(nsh, m_pos / P);
            end else begin
                m_digit = nib(nsh, m_pos / P);
                m_blank = 1'b1;
                m_frame = 1'b0;
            end
            m_shadow = nsh;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset(input logic [15:0] first_load, input logic do_load);
        rst = 1'b1; bus.enable = 1'b1; bus.load = 1'b0; bus.value = '0;
        cycle(); cycle();
        rst = 1'b0;
        if (do_load) begin
            bus.load = 1'b1; bus.value = first_load;
            cycle();
            bus.load = 1'b0;
        end
    endtask

    task automatic run_to(input int s, input int c);
        int n = 0;
        bus.enable = 1'b1; bus.load = 1'b0;
        while (m_pos != s * P + c && n < 200) begin
            cycle();
            n++;
        end
        if (m_pos != s * P + c) begin
            total++; bad++;
            $display("FAIL run_to timeout: pos=%0d required=%0d", m_pos, s * P + c);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.enable = 1'b1; bus.load = 1'b1; bus.value = 16'hFFFF;
        cycle(); cycle();
        total++;
        if (bus.sel !== 2'd0 || bus.digit !== 4'd0 || bus.blank !== 1'b1 || bus.frame !== 1'b0) begin
            bad++;
            $display("FAIL reset: sel=%0d digit=%h blank=%b frame=%b required 0 0 1 0",
                     bus.sel, bus.digit, bus.blank, bus.frame);
        end
    endtask

    task automatic test_first_slot();
        do_reset(16'h0000, 1'b0);
        bus.value = 16'h0000;
        for (int k = 1; k <= 8; k++) begin
            cycle();
            total++;
            if (bus.sel !== ((k == 8) ? 2'd1 : 2'd0) || bus.blank !== ((k % 8) < 2) || bus.digit !== 4'd0) begin
                bad++;
                $display("FAIL first_slot k=%0d: sel=%0d blank=%b digit=%h", k, bus.sel, bus.blank, bus.digit);
            end
        end
    endtask

    task automatic test_sequence();
        logic [3:0] exp_n [4];
        int last_f = -1;
        int nf = 0;
        exp_n[0] = 4'h5; exp_n[1] = 4'hC; exp_n[2] = 4'h3; exp_n[3] = 4'hA;
        do_reset(16'hA3C5, 1'b1);
        for (int k = 2; k <= 100; k++) begin
            cycle();
            total++;
            if (bus.digit !== m_digit || bus.sel !== 2'(m_pos / P) || bus.blank !== m_blank || bus.frame !== m_frame) begin
                bad++;
                $display("FAIL sequence k=%0d: digit=%h sel=%0d blank=%b frame=%b required %h %0d %b %b",
                         k, bus.digit, bus.sel, bus.blank, bus.frame, m_digit, m_pos / P, m_blank, m_frame);
            end
            if (k >= 32 && bus.digit !== exp_n[bus.sel]) begin
                bad++;
                $display("FAIL nibble k=%0d: digit=%h required %h", k, bus.digit, exp_n[bus.sel]);
            end
            if (bus.frame === 1'b1) begin
                nf++;
                if (last_f >= 0) begin
                    total++;
                    if (k - last_f != 32) begin
                        bad++;
                        $display("FAIL frame_period: got %0d required 32", k - last_f);
                    end
                end
                last_f = k;
            end
        end
        total++;
        if (nf != 3) begin
            bad++;
            $display("FAIL frame_count: got %0d required 3", nf);
        end
    endtask

    task automatic test_midslot_load();
        logic [3:0] exp_n [4];
        exp_n[0] = 4'h2; exp_n[1] = 4'h1; exp_n[2] = 4'h4; exp_n[3] = 4'h3;
        do_reset(16'hA3C5, 1'b1);
        run_to(1, 4);
        bus.load = 1'b1; bus.value = 16'h1234;
        cycle();
        bus.load = 1'b0;
        cycle(); cycle();
        total++;
        if (bus.digit !== 4'hC) begin
            bad++;
            $display("FAIL midslot_hold: digit=%h required c", bus.digit);
        end
        for (int s = 0; s < 4; s++) begin
            cycle();
            total++;
            if (bus.digit !== exp_n[s] || bus.digit !== m_digit) begin
                bad++;
                $display("FAIL midslot_slot%0d: digit=%h required %h", s, bus.digit, exp_n[s]);
            end
            for (int k = 0; k < 7; k++) cycle();
        end
    endtask

    task automatic test_back_to_back_boundary_load();
        do_reset(16'hA3C5, 1'b1);
        run_to(0, 7);
        bus.load = 1'b1; bus.value = 16'hBEEF;
        cycle();
        bus.load = 1'b0;
        for (int k = 0; k < 8; k++) begin
            total++;
            if (bus.sel !== 2'd1 || bus.digit !== 4'hE) begin
                bad++;
                $display("FAIL boundary_load k=%0d: sel=%0d digit=%h required 1 e", k, bus.sel, bus.digit);
            end
            cycle();
        end
    endtask

    task automatic test_freeze();
        do_reset(16'hA3C5, 1'b1);
        run_to(2, 5);
        bus.enable = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (k == 4) begin bus.load = 1'b1; bus.value = 16'h0F00; end
            cycle();
            bus.load = 1'b0;
            total++;
            if (bus.sel !== 2'd2 || bus.blank !== 1'b1 || bus.frame !== 1'b0 || bus.digit !== m_digit) begin
                bad++;
                $display("FAIL freeze k=%0d: sel=%0d blank=%b frame=%b digit=%h", k, bus.sel, bus.blank, bus.frame, bus.digit);
            end
        end
        total++;
        if (bus.digit !== 4'hF) begin
            bad++;
            $display("FAIL freeze_digit: digit=%h required f", bus.digit);
        end
        bus.enable = 1'b1;
        cycle();
        total++;
        if (bus.sel !== 2'd2 || bus.blank !== 1'b0) begin
            bad++;
            $display("FAIL reenable_cnt6: sel=%0d blank=%b required 2 0", bus.sel, bus.blank);
        end
        cycle();
        total++;
        if (bus.sel !== 2'd2) begin
            bad++;
            $display("FAIL reenable_cnt7: sel=%0d required 2", bus.sel);
        end
        cycle();
        total++;
        if (bus.sel !== 2'd3 || bus.digit !== 4'h0 || bus.blank !== 1'b1) begin
            bad++;
            $display("FAIL reenable_next: sel=%0d digit=%h blank=%b required 3 0 1", bus.sel, bus.digit, bus.blank);
        end
    endtask

    task automatic test_reset_mid();
        do_reset(16'hA3C5, 1'b1);
        run_to(3, 6);
        rst = 1'b1; bus.load = 1'b1; bus.value = 16'hFFFF;
        cycle();
        rst = 1'b0; bus.load = 1'b0;
        total++;
        if (bus.sel !== 2'd0 || bus.digit !== 4'd0 || bus.blank !== 1'b1 || bus.frame !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid: sel=%0d digit=%h blank=%b frame=%b required 0 0 1 0",
                     bus.sel, bus.digit, bus.blank, bus.frame);
        end
        cycle();
        total++;
        if (bus.blank !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_dead: blank=%b required 1", bus.blank);
        end
        for (int k = 0; k < 40; k++) begin
            cycle();
            total++;
            if (bus.digit !== 4'd0) begin
                bad++;
                $display("FAIL reset_mid_shadow k=%0d: digit=%h required 0", k, bus.digit);
            end
        end
    endtask

    task automatic test_random();
        do_reset(16'h0000, 1'b0);
        for (int k = 0; k < 600; k++) begin
            rst        = ($urandom_range(0, 99) == 0);
            bus.load   = ($urandom_range(0, 9) == 0);
            bus.enable = ($urandom_range(0, 4) != 0);
            bus.value  = 16'($urandom);
            cycle();
            total++;
            if (bus.digit !== m_digit || bus.sel !== 2'(m_pos / P) || bus.blank !== m_blank || bus.frame !== m_frame) begin
                bad++;
                $display("FAIL random k=%0d: digit=%h sel=%0d blank=%b frame=%b required %h %0d %b %b",
                         k, bus.digit, bus.sel, bus.blank, bus.frame, m_digit, m_pos / P, m_blank, m_frame);
            end
        end
        rst = 1'b0; bus.load = 1'b0; bus.enable = 1'b1;
    endtask

    initial begin
        rst = 1'b1; bus.value = '0; bus.load = 1'b0; bus.enable = 1'b0;
        m_pos = 0; m_shadow = '0; m_digit = '0; m_blank = 1'b1; m_frame = 1'b0;
        test_reset();
        test_first_slot();
        test_sequence();
        test_midslot_load();
        test_back_to_back_boundary_load();
        test_freeze();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
